ring_seed_loader: RTL and testbench



---
 rtl/ring_pkg.sv | 49 ++++
 rtl/ring_popcount.sv | 24 ++
 rtl/ring_seed_loader.sv | 203 ++++++++++++++++++++
 tb/tb_ring_seed_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
//   Shared definitions for the ring counter seed loader.
//   - ring_state_t    : loader state encodings
//   - popcount()      : number of set bits in the low w bits of a vector
//   - seed_is_illegal(): true when the low w bits are all 0 or all 1
//   Vectors are passed zero-extended to MAX_W bits so the functions can
//   serve any ring width up to MAX_W.
// ---------------------------------------------------------------------------
package ring_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      APPLY   = 3'd1,
      RELEASE = 3'd2,
      RUN     = 3'd3,
      ERROR   = 3'd4
   } ring_state_t;

   function automatic int unsigned popcount(input logic [MAX_W-1:0] v,
                                            input int unsigned       w);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w && v[i]) n++;
      end
      return n;
   endfunction

   // A ring holding all 0s or all 1s looks identical after rotation,
   // so neither pattern can be checked for corruption.
   function automatic logic seed_is_illegal(input logic [MAX_W-1:0] v,
                                            input int unsigned       w);
      logic all_one;
      logic any_one;
      all_one = 1'b1;
      any_one = 1'b0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w) begin
            all_one = all_one & v[i];
            any_one = any_one | v[i];
         end
      end
      return !any_one || all_one;
   endfunction

endpackage

// File: rtl/ring_popcount.sv
// ---------------------------------------------------------------------------
// ring_popcount
//   Combinational population count of a WIDTH-bit vector.
//   Ports:
//     i_vec   [WIDTH]            vector to count
//     o_count [clog2(WIDTH+1)]   number of set bits
// ---------------------------------------------------------------------------
module ring_popcount
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]             i_vec,
   output logic [$clog2(WIDTH+1)-1:0]   o_count
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [MAX_W-1:0] w_ext;

   assign w_ext   = MAX_W'(i_vec);
   assign o_count = CW'(popcount(w_ext, WIDTH));

endmodule

// File: rtl/ring_seed_loader.sv
// ---------------------------------------------------------------------------
// ring_seed_loader
//   Loads a seed pattern into a preset/reset D-flip-flop ring counter by
//   driving its active-low per-bit preset/reset vectors for HOLD_CYCLES
//   cycles, releases the ring for one cycle, then monitors it while it runs.
//   Corruption (seed not taken, or popcount drift while running) raises a
//   fault pulse and reloads the seed up to MAX_RETRY times before ERROR.
//   Ports:
//     clk        rising-edge clock shared with the ring
//     rst        asynchronous active-high reset
//     start      load request, honoured in IDLE or ERROR
//     stop       abort to IDLE from any state, wins over start
//     seed       pattern to load (bit i = 1 -> ring q[i] = 1)
//     ring_q     ring q feedback
//     preset_n   active-low per-bit preset to ring
//     reset_n    active-low per-bit reset to ring
//     busy       high in APPLY or RELEASE
//     running    high in RUN
//     fault      one-cycle pulse per detected fault
//     error      high in ERROR
//     seed_err   one-cycle pulse when start carries an illegal seed
//     retry_cnt  reloads since the last accepted start
// ---------------------------------------------------------------------------
module ring_seed_loader
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned AUTO_RELOAD = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               stop,
   input  logic [WIDTH-1:0]                   seed,
   input  logic [WIDTH-1:0]                   ring_q,
   output logic [WIDTH-1:0]                   preset_n,
   output logic [WIDTH-1:0]                   reset_n,
   output logic                               busy,
   output logic                               running,
   output logic                               fault,
   output logic                               error,
   output logic                               seed_err,
   output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 1);
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   ring_state_t       r_state;
   logic [WIDTH-1:0]  r_seed;
   logic [HW-1:0]     r_hold;
   logic [RW-1:0]     r_retry;
   logic [WIDTH-1:0]  r_preset_n;
   logic [WIDTH-1:0]  r_reset_n;
   logic              r_busy;
   logic              r_running;
   logic              r_fault;
   logic              r_error;
   logic              r_seed_err;

   logic [MAX_W-1:0]  w_seed_ext;
   logic              w_seed_bad;
   logic [CW-1:0]     w_q_pop;
   logic [CW-1:0]     w_seed_pop;
   logic              w_can_retry;

   assign w_seed_ext  = MAX_W'(seed);
   assign w_seed_bad  = seed_is_illegal(w_seed_ext, WIDTH);
   assign w_can_retry = (r_retry < RETRY_MAX);

   ring_popcount #(.WIDTH(WIDTH)) u_pop_q (
      .i_vec   (ring_q),
      .o_count (w_q_pop)
   );

   ring_popcount #(.WIDTH(WIDTH)) u_pop_seed (
      .i_vec   (r_seed),
      .o_count (w_seed_pop)
   );

   // Outputs are written together with the next state so every output
   // changes on the edge that enters the corresponding state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_seed     <= '0;
         r_hold     <= '0;
         r_retry    <= '0;
         r_preset_n <= '1;
         r_reset_n  <= '1;
         r_busy     <= 1'b0;
         r_running  <= 1'b0;
         r_fault    <= 1'b0;
         r_error    <= 1'b0;
         r_seed_err <= 1'b0;
      end else begin
         r_fault    <= 1'b0;
         r_seed_err <= 1'b0;
         if (stop) begin
            r_state    <= IDLE;
            r_preset_n <= '1;
            r_reset_n  <= '1;
            r_busy     <= 1'b0;
            r_running  <= 1'b0;
            r_error    <= 1'b0;
         end else begin
            case (r_state)
               IDLE, ERROR: begin
                  if (start) begin
                     if (w_seed_bad) begin
                        r_seed_err <= 1'b1;
                     end else begin
                        r_state    <= APPLY;
                        r_seed     <= seed;
                        r_retry    <= '0;
                        r_hold     <= '0;
                        r_preset_n <= ~seed;
                        r_reset_n  <= seed;
                        r_busy     <= 1'b1;
                        r_running  <= 1'b0;
                        r_error    <= 1'b0;
                     end
                  end
               end

               APPLY: begin
                  if (r_hold != HOLD_LAST) begin
                     r_hold <= r_hold + HW'(1);
                  end else if (ring_q == r_seed) begin
                     r_state    <= RELEASE;
                     r_preset_n <= '1;
                     r_reset_n  <= '1;
                  end else begin
                     r_fault <= 1'b1;
                     if (w_can_retry) begin
                        r_retry    <= r_retry + RW'(1);
                        r_hold     <= '0;
                        r_preset_n <= ~r_seed;
                        r_reset_n  <= r_seed;
                     end else begin
                        r_state    <= ERROR;
                        r_preset_n <= '1;
                        r_reset_n  <= '1;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                     end
                  end
               end

               RELEASE: begin
                  r_state   <= RUN;
                  r_busy    <= 1'b0;
                  r_running <= 1'b1;
               end

               RUN: begin
                  // Rotation preserves the number of ones in the ring.
                  if (w_q_pop != w_seed_pop) begin
                     r_fault   <= 1'b1;
                     r_running <= 1'b0;
                     if (AUTO_RELOAD != 0 && w_can_retry) begin
                        r_state    <= APPLY;
                        r_retry    <= r_retry + RW'(1);
                        r_hold     <= '0;
                        r_preset_n <= ~r_seed;
                        r_reset_n  <= r_seed;
                        r_busy     <= 1'b1;
                     end else begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                     end
                  end
               end

               default: begin
                  r_state    <= IDLE;
                  r_preset_n <= '1;
                  r_reset_n  <= '1;
                  r_busy     <= 1'b0;
                  r_running  <= 1'b0;
                  r_error    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign preset_n  = r_preset_n;
   assign reset_n   = r_reset_n;
   assign busy      = r_busy;
   assign running   = r_running;
   assign fault     = r_fault;
   assign error     = r_error;
   assign seed_err  = r_seed_err;
   assign retry_cnt = r_retry;

endmodule

// File: tb/tb_ring_seed_loader.sv
// ---------------------------------------------------------------------------
// tb_ring_seed_loader
//   Directed bench for ring_seed_loader (WIDTH=4, HOLD_CYCLES=2,
//   MAX_RETRY=3, AUTO_RELOAD=1) with a behavioural 4-bit preset/reset ring.
//   ring_q can be overridden to inject corruption.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ring_seed_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] seed = 4'b0000;
   logic [3:0] ring_q;
   logic [3:0] preset_n;
   logic [3:0] reset_n;
   logic       busy;
   logic       running;
   logic       fault;
   logic       error;
   logic       seed_err;
   logic [1:0] retry_cnt;

   int errors = 0;
   int checks = 0;

   // Behavioural ring: asynchronous preset/reset override, rotate left
   // on every clock while both vectors are released.
   logic [3:0] ring = 4'b0000;
   logic [3:0] q_eff;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'b0000;

   assign q_eff  = ~preset_n | (reset_n & ring);
   assign ring_q = force_en ? force_val : q_eff;

   always @(posedge clk) begin
      if (&preset_n && &reset_n) ring <= {q_eff[2:0], q_eff[3]};
      else                       ring <= q_eff;
   end

   always #5 clk = ~clk;

   ring_seed_loader #(
      .WIDTH       (4),
      .HOLD_CYCLES (2),
      .MAX_RETRY   (3),
      .AUTO_RELOAD (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .seed      (seed),
      .ring_q    (ring_q),
      .preset_n  (preset_n),
      .reset_n   (reset_n),
      .busy      (busy),
      .running   (running),
      .fault     (fault),
      .error     (error),
      .seed_err  (seed_err),
      .retry_cnt (retry_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (preset_n !== 4'b1111) begin errors++; $display("FAIL reset_preset_n: got %b expected 1111", preset_n); end
      checks++; if (reset_n !== 4'b1111) begin errors++; $display("FAIL reset_reset_n: got %b expected 1111", reset_n); end
      checks++; if ({busy, running, fault, error, seed_err} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, running, fault, error, seed_err}); end
      checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_load;
      logic [3:0] exp_q;
      start = 1'b1; seed = 4'b0001;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (preset_n !== 4'b1110) begin errors++; $display("FAIL load_apply_preset_n[%0d]: got %b expected 1110", i, preset_n); end
         checks++; if (reset_n !== 4'b0001) begin errors++; $display("FAIL load_apply_reset_n[%0d]: got %b expected 0001", i, reset_n); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_apply_busy[%0d]: got %b expected 1", i, busy); end
         checks++; if ((~preset_n & ~reset_n) !== 4'b0000) begin errors++; $display("FAIL load_apply_both_low[%0d]: got %b expected 0000", i, ~preset_n & ~reset_n); end
         tick();
      end
      checks++; if ({preset_n, reset_n} !== 8'hFF) begin errors++; $display("FAIL load_release_vectors: got %h expected ff", {preset_n, reset_n}); end
      checks++; if ({busy, running} !== 2'b10) begin errors++; $display("FAIL load_release_flags: got %b expected 10", {busy, running}); end
      tick();
      checks++; if ({busy, running} !== 2'b01) begin errors++; $display("FAIL load_run_flags: got %b expected 01", {busy, running}); end
      exp_q = 4'b0010;
      for (int i = 0; i < 8; i++) begin
         checks++; if (ring_q !== exp_q) begin errors++; $display("FAIL load_rotate[%0d]: got %b expected %b", i, ring_q, exp_q); end
         checks++; if ({running, fault} !== 2'b10) begin errors++; $display("FAIL load_run_nofault[%0d]: got %b expected 10", i, {running, fault}); end
         exp_q = {exp_q[2:0], exp_q[3]};
         tick();
      end
      checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL load_retry: got %0d expected 0", retry_cnt); end
   endtask

   task automatic test_illegal_seed;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if ({running, busy} !== 2'b00) begin errors++; $display("FAIL stop_run_flags: got %b expected 00", {running, busy}); end
      for (int k = 0; k < 2; k++) begin
         start = 1'b1; seed = (k == 0) ? 4'b0000 : 4'b1111;
         tick();
         start = 1'b0;
         checks++; if (seed_err !== 1'b1) begin errors++; $display("FAIL illegal_seed_err[%0d]: got %b expected 1", k, seed_err); end
         checks++; if ({preset_n, reset_n} !== 8'hFF) begin errors++; $display("FAIL illegal_vectors[%0d]: got %h expected ff", k, {preset_n, reset_n}); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy[%0d]: got %b expected 0", k, busy); end
         tick();
         checks++; if ({seed_err, busy} !== 2'b00) begin errors++; $display("FAIL illegal_pulse_end[%0d]: got %b expected 00", k, {seed_err, busy}); end
      end
   endtask

   task automatic test_run_fault;
      logic [1:0] exp_r;
      start = 1'b1; seed = 4'b0001;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      for (int k = 1; k <= 4; k++) begin
         checks++; if (running !== 1'b1) begin errors++; $display("FAIL runfault_pre_running[%0d]: got %b expected 1", k, running); end
         force_val = 4'b0011; force_en = 1'b1;
         tick();
         force_en = 1'b0;
         exp_r = (k < 3) ? 2'(k) : 2'd3;
         checks++; if (fault !== 1'b1) begin errors++; $display("FAIL runfault_pulse[%0d]: got %b expected 1", k, fault); end
         checks++; if (retry_cnt !== exp_r) begin errors++; $display("FAIL runfault_retry[%0d]: got %0d expected %0d", k, retry_cnt, exp_r); end
         if (k < 4) begin
            checks++; if ({preset_n, reset_n} !== 8'hE1) begin errors++; $display("FAIL runfault_reapply[%0d]: got %h expected e1", k, {preset_n, reset_n}); end
            checks++; if ({busy, running, error} !== 3'b100) begin errors++; $display("FAIL runfault_flags[%0d]: got %b expected 100", k, {busy, running, error}); end
         end else begin
            checks++; if ({preset_n, reset_n} !== 8'hFF) begin errors++; $display("FAIL runfault_err_vectors: got %h expected ff", {preset_n, reset_n}); end
            checks++; if ({busy, running, error} !== 3'b001) begin errors++; $display("FAIL runfault_err_flags: got %b expected 001", {busy, running, error}); end
         end
         tick();
         checks++; if (fault !== 1'b0) begin errors++; $display("FAIL runfault_pulse_end[%0d]: got %b expected 0", k, fault); end
         if (k < 4) begin
            tick(); tick();
         end
      end
   endtask

   task automatic test_apply_mismatch;
      logic [1:0] exp_r;
      force_val = 4'b0000; force_en = 1'b1;
      start = 1'b1; seed = 4'b0010;
      tick();
      start = 1'b0;
      checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL apply_err_start_retry: got %0d expected 0", retry_cnt); end
      checks++; if ({preset_n, reset_n} !== 8'hD2) begin errors++; $display("FAIL apply_err_start_vectors: got %h expected d2", {preset_n, reset_n}); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL apply_err_start_error: got %b expected 0", error); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (fault !== 1'b0) begin errors++; $display("FAIL apply_hold_nofault[%0d]: got %b expected 0", k, fault); end
         tick();
         exp_r = (k < 3) ? 2'(k) : 2'd3;
         checks++; if (fault !== 1'b1) begin errors++; $display("FAIL apply_mismatch_fault[%0d]: got %b expected 1", k, fault); end
         checks++; if (retry_cnt !== exp_r) begin errors++; $display("FAIL apply_mismatch_retry[%0d]: got %0d expected %0d", k, retry_cnt, exp_r); end
         checks++; if (error !== (k == 4)) begin errors++; $display("FAIL apply_mismatch_error[%0d]: got %b expected %b", k, error, (k == 4)); end
      end
      // legal start out of ERROR, ring still stuck at 0000
      start = 1'b1; seed = 4'b0001;
      tick();
      start = 1'b0;
      checks++; if ({retry_cnt, busy, error} !== 4'b0010) begin errors++; $display("FAIL error_restart: got %b expected 0010", {retry_cnt, busy, error}); end
      tick(); tick();
      checks++; if ({fault, retry_cnt} !== 3'b101) begin errors++; $display("FAIL error_restart_fault: got %b expected 101", {fault, retry_cnt}); end
   endtask

   task automatic test_stop_start;
      stop = 1'b1; start = 1'b1; seed = 4'b0100;
      tick();
      stop = 1'b0; start = 1'b0;
      force_en = 1'b0;
      checks++; if ({preset_n, reset_n} !== 8'hFF) begin errors++; $display("FAIL stopstart_vectors: got %h expected ff", {preset_n, reset_n}); end
      checks++; if ({busy, running, error, seed_err} !== 4'b0000) begin errors++; $display("FAIL stopstart_flags: got %b expected 0000", {busy, running, error, seed_err}); end
      checks++; if (retry_cnt !== 2'd1) begin errors++; $display("FAIL stopstart_retry_held: got %0d expected 1", retry_cnt); end
      tick();
      checks++; if ({busy, preset_n} !== 5'b01111) begin errors++; $display("FAIL stopstart_start_ignored: got %b expected 01111", {busy, preset_n}); end
   endtask

   task automatic test_async_reset;
      start = 1'b1; seed = 4'b0110;
      tick();
      start = 1'b0;
      checks++; if ({preset_n, reset_n} !== 8'h96) begin errors++; $display("FAIL arst_apply_vectors: got %h expected 96", {preset_n, reset_n}); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({preset_n, reset_n} !== 8'hFF) begin errors++; $display("FAIL arst_vectors: got %h expected ff", {preset_n, reset_n}); end
      checks++; if ({busy, retry_cnt} !== 3'b000) begin errors++; $display("FAIL arst_busy_retry: got %b expected 000", {busy, retry_cnt}); end
      #2 rst = 1'b0;
      tick();
      checks++; if ({busy, preset_n, reset_n} !== 9'h0FF) begin errors++; $display("FAIL arst_idle: got %h expected 0ff", {busy, preset_n, reset_n}); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_illegal_seed();
      test_run_fault();
      test_apply_mismatch();
      test_stop_start();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
